rename_map_table_ckpt: RTL and testbench

- W-wide speculative register rename map with intra-group bypass for any W, plus CKPT_NUM in-order branch checkpoints for one-cycle misprediction recovery.
- Also keeps an architectural (committed) map, updated from the commit PRF tags, for exception recovery.
- Sits in the rename stage between decode/free list and dispatch; fed by ROB commit and branch resolution.

---
 rtl/rename_pkg.sv | 22 ++
 rtl/rename_bypass_net.sv | 57 +++++
 rtl/rename_map_table_ckpt.sv | 144 ++++++++++++++
 tb/tb_rename_map_table_ckpt.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared types and sizes for the rename map table.
// The map type is a packed array indexed by architectural register.
package rename_pkg;

    localparam int ARF_NUM  = 32;
    localparam int ARF_W    = 5;
    localparam int PRF_NUM  = 64;
    localparam int PRF_W    = $clog2(PRF_NUM);
    localparam int CKPT_NUM = 4;
    localparam int CK_W     = $clog2(CKPT_NUM);

    typedef logic [ARF_NUM-1:0][PRF_W-1:0] map_t;

    function automatic map_t identity_map();
        map_t m;
        for (int i = 0; i < ARF_NUM; i++) begin
            m[i] = PRF_W'(i);
        end
        return m;
    endfunction

endpackage

// File: rtl/rename_bypass_net.sv
// W-slot priority bypass: each slot sees the writes of older slots
// in the same group before falling back to the speculative map.
module rename_bypass_net
    import rename_pkg::*;
#(
    parameter int W = 2
) (
    input  logic [W-1:0]       valid,
    input  logic [W-1:0]       wr,
    input  logic [W*ARF_W-1:0] rs1,
    input  logic [W*ARF_W-1:0] rs2,
    input  logic [W*ARF_W-1:0] rd,
    input  logic [W*PRF_W-1:0] prd_new,
    input  map_t               spec,
    output logic [W*PRF_W-1:0] prs1,
    output logic [W*PRF_W-1:0] prs2,
    output logic [W*PRF_W-1:0] prd_stale
);

    function automatic logic [PRF_W-1:0] resolve(
        input int                 slot,
        input logic [ARF_W-1:0]   a,
        input logic [W-1:0]       v,
        input logic [W-1:0]       w,
        input logic [W*ARF_W-1:0] d,
        input logic [W*PRF_W-1:0] n,
        input map_t               m
    );
        logic [PRF_W-1:0] t;
        t = m[a];
        for (int j = 0; j < W; j++) begin
            if (j < slot && v[j] && w[j] && d[j*ARF_W +: ARF_W] == a) begin
                t = n[j*PRF_W +: PRF_W];
            end
        end
        if (a == '0) begin
            t = '0;
        end
        return t;
    endfunction

    // youngest older in-group writer wins, arf 0 always maps to tag 0
    always_comb begin
        prs1      = '0;
        prs2      = '0;
        prd_stale = '0;
        for (int i = 0; i < W; i++) begin
            prs1[i*PRF_W +: PRF_W] =
                resolve(i, rs1[i*ARF_W +: ARF_W], valid, wr, rd, prd_new, spec);
            prs2[i*PRF_W +: PRF_W] =
                resolve(i, rs2[i*ARF_W +: ARF_W], valid, wr, rd, prd_new, spec);
            prd_stale[i*PRF_W +: PRF_W] =
                resolve(i, rd[i*ARF_W +: ARF_W], valid, wr, rd, prd_new, spec);
        end
    end

endmodule

// File: rtl/rename_map_table_ckpt.sv
// Speculative rename map with in-order branch checkpoints and a
// committed map for exception recovery.
module rename_map_table_ckpt
    import rename_pkg::*;
#(
    parameter int W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         ren_valid,
    input  logic [W-1:0]         ren_wr,
    input  logic [W*ARF_W-1:0]   ren_rs1,
    input  logic [W*ARF_W-1:0]   ren_rs2,
    input  logic [W*ARF_W-1:0]   ren_rd,
    input  logic [W*PRF_W-1:0]   ren_prd_new,
    input  logic [W-1:0]         ren_ckpt_req,
    output logic                 ren_stall,
    output logic [W*PRF_W-1:0]   ren_prs1,
    output logic [W*PRF_W-1:0]   ren_prs2,
    output logic [W*PRF_W-1:0]   ren_prd_stale,
    output logic [CK_W-1:0]      ren_ckpt_id,
    input  logic                 ckpt_release,
    input  logic                 rec_ckpt,
    input  logic [CK_W-1:0]      rec_ckpt_id,
    input  logic                 rec_commit,
    input  logic [W-1:0]         cm_valid,
    input  logic [W*ARF_W-1:0]   cm_arf,
    input  logic [W*PRF_W-1:0]   cm_prf,
    output logic [CK_W:0]        ckpt_count
);

    map_t             spec_q;
    map_t             comm_q;
    map_t             spec_nxt;
    map_t             snap_nxt;
    map_t             comm_nxt;
    map_t             snap_q [CKPT_NUM];
    logic [CK_W-1:0]  head_q;
    logic [CK_W-1:0]  tail_q;
    logic [CK_W:0]    count_q;

    logic             recover;
    logic             alloc_req;
    logic             full;
    logic             ren_go;
    logic             alloc;
    logic             rel_ok;
    logic             rec_rel;
    logic [CK_W-1:0]  rec_dist;
    logic [CK_W:0]    rec_cnt;

    assign recover     = rec_commit | rec_ckpt;
    assign alloc_req   = |(ren_ckpt_req & ren_valid);
    assign full        = count_q == (CK_W+1)'(CKPT_NUM);
    assign ren_stall   = ~recover & alloc_req & full;
    assign ren_go      = ~recover & ~ren_stall;
    assign alloc       = ren_go & alloc_req;
    assign ren_ckpt_id = tail_q;
    assign ckpt_count  = count_q;

    assign rel_ok   = ckpt_release & (count_q != '0);
    assign rec_rel  = rel_ok & (head_q != rec_ckpt_id);
    assign rec_dist = rec_ckpt_id - head_q + CK_W'(1);
    assign rec_cnt  = (rec_dist == '0 && full) ?
                      (CK_W+1)'(CKPT_NUM) : {1'b0, rec_dist};

    rename_bypass_net #(.W(W)) u_bypass (
        .valid     (ren_valid),
        .wr        (ren_wr),
        .rs1       (ren_rs1),
        .rs2       (ren_rs2),
        .rd        (ren_rd),
        .prd_new   (ren_prd_new),
        .spec      (spec_q),
        .prs1      (ren_prs1),
        .prs2      (ren_prs2),
        .prd_stale (ren_prd_stale)
    );

    // walk the group slot by slot; the snapshot stops at the branch slot
    always_comb begin
        spec_nxt = spec_q;
        snap_nxt = spec_q;
        for (int i = 0; i < W; i++) begin
            if (ren_valid[i] && ren_wr[i] &&
                ren_rd[i*ARF_W +: ARF_W] != '0) begin
                spec_nxt[ren_rd[i*ARF_W +: ARF_W]] =
                    ren_prd_new[i*PRF_W +: PRF_W];
            end
            if (ren_valid[i] && ren_ckpt_req[i]) begin
                snap_nxt = spec_nxt;
            end
        end
    end

    // committed map after this cycle's retirements, higher slot wins
    always_comb begin
        comm_nxt = comm_q;
        for (int i = 0; i < W; i++) begin
            if (cm_valid[i] && cm_arf[i*ARF_W +: ARF_W] != '0) begin
                comm_nxt[cm_arf[i*ARF_W +: ARF_W]] = cm_prf[i*PRF_W +: PRF_W];
            end
        end
    end

    // map state and checkpoint ring pointers with recovery priority
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_q  <= identity_map();
            comm_q  <= identity_map();
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            comm_q <= comm_nxt;
            if (rec_commit) begin
                spec_q  <= comm_nxt;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else if (rec_ckpt) begin
                spec_q  <= snap_q[rec_ckpt_id];
                tail_q  <= rec_ckpt_id + CK_W'(1);
                count_q <= rec_cnt - (CK_W+1)'(rec_rel);
                head_q  <= head_q + CK_W'(rec_rel);
            end else begin
                if (ren_go) begin
                    spec_q <= spec_nxt;
                end
                tail_q  <= tail_q + CK_W'(alloc);
                head_q  <= head_q + CK_W'(rel_ok);
                count_q <= count_q + (CK_W+1)'(alloc) - (CK_W+1)'(rel_ok);
            end
        end
    end

    // snapshot storage written at the tail on each accepted branch
    always_ff @(posedge clk) begin
        if (!rst && alloc) begin
            snap_q[tail_q] <= snap_nxt;
        end
    end

endmodule

// File: tb/tb_rename_map_table_ckpt.sv
// Randomized bench with a queue-based behavioural model of the
// rename map, checkpoints and committed map.
module tb_rename_map_table_ckpt;

    localparam int W   = 2;
    localparam int PW  = 6;
    localparam int CW  = 2;
    localparam int NCK = 4;

    typedef logic [31:0][PW-1:0] mmap_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [W-1:0]    ren_valid, ren_wr, ren_ckpt_req, cm_valid;
    logic [W*5-1:0]  ren_rs1, ren_rs2, ren_rd, cm_arf;
    logic [W*PW-1:0] ren_prd_new, cm_prf;
    logic [W*PW-1:0] ren_prs1, ren_prs2, ren_prd_stale;
    logic            ren_stall;
    logic [CW-1:0]   ren_ckpt_id, rec_ckpt_id;
    logic            ckpt_release, rec_ckpt, rec_commit;
    logic [CW:0]     ckpt_count;

    rename_map_table_ckpt #(.W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .ren_valid     (ren_valid),
        .ren_wr        (ren_wr),
        .ren_rs1       (ren_rs1),
        .ren_rs2       (ren_rs2),
        .ren_rd        (ren_rd),
        .ren_prd_new   (ren_prd_new),
        .ren_ckpt_req  (ren_ckpt_req),
        .ren_stall     (ren_stall),
        .ren_prs1      (ren_prs1),
        .ren_prs2      (ren_prs2),
        .ren_prd_stale (ren_prd_stale),
        .ren_ckpt_id   (ren_ckpt_id),
        .ckpt_release  (ckpt_release),
        .rec_ckpt      (rec_ckpt),
        .rec_ckpt_id   (rec_ckpt_id),
        .rec_commit    (rec_commit),
        .cm_valid      (cm_valid),
        .cm_arf        (cm_arf),
        .cm_prf        (cm_prf),
        .ckpt_count    (ckpt_count)
    );

    always #5 clk = ~clk;

    mmap_t spec_m, comm_m;
    mmap_t qmap[$];
    int    qid[$];
    int    next_id;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    e1[W], e2[W], es[W];
    mmap_t walk_fin, walk_snap;
    bit    walk_req;

    function automatic mmap_t ident();
        mmap_t m;
        for (int i = 0; i < 32; i++) m[i] = PW'(i);
        return m;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic clr();
        ren_valid = '0; ren_wr = '0; ren_ckpt_req = '0;
        ren_rs1 = '0; ren_rs2 = '0; ren_rd = '0; ren_prd_new = '0;
        ckpt_release = 0; rec_ckpt = 0; rec_ckpt_id = '0; rec_commit = 0;
        cm_valid = '0; cm_arf = '0; cm_prf = '0;
    endtask

    task automatic set_slot(input int i, input bit v, input bit w,
                            input int a1, input int a2, input int d,
                            input int n);
        ren_valid[i] = v;
        ren_wr[i] = w;
        ren_rs1[i*5 +: 5] = 5'(a1);
        ren_rs2[i*5 +: 5] = 5'(a2);
        ren_rd[i*5 +: 5] = 5'(d);
        ren_prd_new[i*PW +: PW] = PW'(n);
    endtask

    // group renamed as a sequence of single instructions over a map copy
    task automatic model_walk();
        mmap_t t;
        t = spec_m;
        walk_snap = spec_m;
        walk_req = 0;
        for (int i = 0; i < W; i++) begin
            int a1, a2, d;
            a1 = int'(ren_rs1[i*5 +: 5]);
            a2 = int'(ren_rs2[i*5 +: 5]);
            d  = int'(ren_rd[i*5 +: 5]);
            e1[i] = (a1 == 0) ? 0 : int'(t[a1]);
            e2[i] = (a2 == 0) ? 0 : int'(t[a2]);
            es[i] = (d == 0) ? 0 : int'(t[d]);
            if (ren_valid[i] && ren_wr[i] && d != 0)
                t[d] = ren_prd_new[i*PW +: PW];
            if (ren_valid[i] && ren_ckpt_req[i]) begin
                walk_snap = t;
                walk_req = 1;
            end
        end
        walk_fin = t;
    endtask

    task automatic check_cycle();
        bit st;
        @(negedge clk);
        model_walk();
        st = !rec_commit && !rec_ckpt && walk_req && qid.size() == NCK;
        chk("stall", int'(ren_stall), int'(st));
        chk("count", int'(ckpt_count), qid.size());
        chk("ckpt_id", int'(ren_ckpt_id), next_id);
        for (int i = 0; i < W; i++) begin
            if (ren_valid[i]) begin
                chk($sformatf("prs1[%0d]", i),
                    int'(ren_prs1[i*PW +: PW]), e1[i]);
                chk($sformatf("prs2[%0d]", i),
                    int'(ren_prs2[i*PW +: PW]), e2[i]);
                chk($sformatf("stale[%0d]", i),
                    int'(ren_prd_stale[i*PW +: PW]), es[i]);
            end
        end
    endtask

    task automatic advance();
        mmap_t nc;
        int    idx;
        @(posedge clk);
        if (rst) begin
            spec_m = ident();
            comm_m = ident();
            qid.delete();
            qmap.delete();
            next_id = 0;
        end else begin
            nc = comm_m;
            for (int i = 0; i < W; i++)
                if (cm_valid[i] && cm_arf[i*5 +: 5] != 0)
                    nc[cm_arf[i*5 +: 5]] = cm_prf[i*PW +: PW];
            model_walk();
            if (rec_commit) begin
                spec_m = nc;
                qid.delete();
                qmap.delete();
                next_id = 0;
            end else if (rec_ckpt) begin
                if (ckpt_release && qid.size() > 0 &&
                    qid[0] != int'(rec_ckpt_id)) begin
                    void'(qid.pop_front());
                    void'(qmap.pop_front());
                end
                idx = -1;
                foreach (qid[k]) if (qid[k] == int'(rec_ckpt_id)) idx = k;
                chk("rec_live", int'(idx >= 0), 1);
                if (idx >= 0) begin
                    spec_m = qmap[idx];
                    while (qid.size() > idx + 1) begin
                        void'(qid.pop_back());
                        void'(qmap.pop_back());
                    end
                end
                next_id = (int'(rec_ckpt_id) + 1) % NCK;
            end else begin
                bit st;
                st = walk_req && qid.size() == NCK;
                if (ckpt_release && qid.size() > 0) begin
                    void'(qid.pop_front());
                    void'(qmap.pop_front());
                end
                if (!st) begin
                    spec_m = walk_fin;
                    if (walk_req) begin
                        qid.push_back(next_id);
                        qmap.push_back(walk_snap);
                        next_id = (next_id + 1) % NCK;
                    end
                end
            end
            comm_m = nc;
        end
        #1;
    endtask

    function automatic int rarf();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
        return int'($urandom_range(0, 7));
    endfunction

    task automatic rand_inputs();
        int k;
        clr();
        for (int i = 0; i < W; i++) begin
            set_slot(i, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     rarf(), rarf(), rarf(), int'($urandom_range(0, 63)));
            cm_valid[i] = $urandom_range(0, 1) == 1;
            cm_arf[i*5 +: 5] = 5'(rarf());
            cm_prf[i*PW +: PW] = PW'($urandom_range(0, 63));
        end
        if ($urandom_range(0, 2) == 0) begin
            k = int'($urandom_range(0, W - 1));
            ren_ckpt_req[k] = 1;
            ren_valid[k] = 1;
        end
        ckpt_release = $urandom_range(0, 3) == 0;
        if (qid.size() > 0 && $urandom_range(0, 11) == 0) begin
            rec_ckpt = 1;
            k = int'($urandom_range(0, qid.size() - 1));
            rec_ckpt_id = CW'(qid[k]);
        end
        rec_commit = $urandom_range(0, 39) == 0;
    endtask

    initial begin
        clr();
        rst = 1;
        repeat (2) advance();
        rst = 0;

        // plain read after reset
        set_slot(0, 1, 0, 3, 0, 4, 0);
        check_cycle();
        chk("lit_rst_count", int'(ckpt_count), 0);
        chk("lit_rst_stall", int'(ren_stall), 0);
        chk("lit_prs1_3", int'(ren_prs1[PW-1:0]), 3);
        chk("lit_prs2_0", int'(ren_prs2[PW-1:0]), 0);
        chk("lit_stale_4", int'(ren_prd_stale[PW-1:0]), 4);
        advance();

        // in-group bypass
        clr();
        set_slot(0, 1, 1, 0, 0, 5, 40);
        set_slot(1, 1, 1, 5, 0, 5, 41);
        check_cycle();
        chk("lit_byp_prs1", int'(ren_prs1[2*PW-1:PW]), 40);
        chk("lit_byp_stale", int'(ren_prd_stale[2*PW-1:PW]), 40);
        advance();
        clr();
        set_slot(0, 1, 0, 5, 0, 0, 0);
        check_cycle();
        chk("lit_read5", int'(ren_prs1[PW-1:0]), 41);
        advance();

        // checkpoint excludes later slot, then recover to it
        clr();
        set_slot(0, 1, 1, 0, 0, 7, 42);
        set_slot(1, 1, 1, 0, 0, 7, 43);
        ren_ckpt_req = 2'b01;
        check_cycle();
        chk("lit_ckid0", int'(ren_ckpt_id), 0);
        advance();
        clr();
        set_slot(0, 1, 0, 7, 0, 0, 0);
        check_cycle();
        chk("lit_read7a", int'(ren_prs1[PW-1:0]), 43);
        advance();
        clr();
        rec_ckpt = 1;
        rec_ckpt_id = '0;
        check_cycle();
        advance();
        clr();
        set_slot(0, 1, 0, 7, 0, 0, 0);
        check_cycle();
        chk("lit_read7b", int'(ren_prs1[PW-1:0]), 42);
        chk("lit_cnt1", int'(ckpt_count), 1);
        advance();

        // fill the ring, stall, release, wrap to id 0
        for (int n = 1; n < NCK; n++) begin
            clr();
            set_slot(0, 1, 0, 0, 0, 0, 0);
            ren_ckpt_req = 2'b01;
            check_cycle();
            chk("lit_fill_id", int'(ren_ckpt_id), n);
            advance();
        end
        clr();
        set_slot(0, 1, 1, 0, 0, 10, 55);
        ren_ckpt_req = 2'b01;
        check_cycle();
        chk("lit_full_stall", int'(ren_stall), 1);
        advance();
        clr();
        set_slot(0, 1, 0, 10, 0, 0, 0);
        ckpt_release = 1;
        check_cycle();
        chk("lit_no_write", int'(ren_prs1[PW-1:0]), 10);
        chk("lit_cnt4", int'(ckpt_count), 4);
        advance();
        clr();
        set_slot(0, 1, 0, 0, 0, 0, 0);
        ren_ckpt_req = 2'b01;
        check_cycle();
        chk("lit_wrap_stall", int'(ren_stall), 0);
        chk("lit_wrap_id", int'(ren_ckpt_id), 0);
        advance();

        // exception recovery picks up same-cycle commit
        clr();
        set_slot(0, 1, 1, 0, 0, 9, 61);
        rec_commit = 1;
        cm_valid = 2'b01;
        cm_arf[4:0] = 5'd9;
        cm_prf[PW-1:0] = PW'(50);
        check_cycle();
        advance();
        clr();
        set_slot(0, 1, 0, 9, 0, 0, 0);
        check_cycle();
        chk("lit_read9", int'(ren_prs1[PW-1:0]), 50);
        chk("lit_cnt0", int'(ckpt_count), 0);
        advance();

        // writes and commits to arf 0 have no effect
        clr();
        set_slot(0, 1, 1, 0, 0, 0, 60);
        cm_valid = 2'b01;
        cm_prf[PW-1:0] = PW'(33);
        check_cycle();
        advance();
        clr();
        set_slot(0, 1, 0, 0, 0, 0, 0);
        check_cycle();
        chk("lit_zero_src", int'(ren_prs1[PW-1:0]), 0);
        chk("lit_zero_stale", int'(ren_prd_stale[PW-1:0]), 0);
        advance();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            check_cycle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
